hamming_argmin: RTL and testbench
=================================

// Module: hamming_argmin
// PURPOSE
// - Streaming associative-search stage. Sits directly downstream of Popcount.
// - Consumes per-segment popcounts of (query XOR class hypervector), one segment per beat.
// - Accumulates the segments into a Hamming distance per class.
// - Outputs the index and distance of the nearest class (minimum distance) once per query.
// PARAMETERS
// - PCW   6   width of one segment popcount (DW=32 segment -> 0..32)
// - NSEG  32  segments per hypervector (1024-bit HV at DW=32)
// - NC    10  number of classes per query, >= 2
// - DISTW PCW+$clog2(NSEG)  distance width, derived; do not override
// - CIW   $clog2(NC)        class index width, derived; do not override
// PORTS
// - clk_i        in   1      clock, all state updates on rising edge
// - rst_i        in   1      synchronous, active-high reset
// - in_valid_i   in   1      pc_i valid
// - in_ready_o   out  1      stage can accept a beat
// - pc_i         in   PCW    segment popcount
// - out_valid_o  out  1      result valid
// - out_ready_i  in   1      downstream accepts result
// - class_o      out  CIW    index of nearest class
// - dist_o       out  DISTW  Hamming distance of nearest class
// BEHAVIOUR
// - Reset values: state=ACCUM, in_ready_o=1, out_valid_o=0, class_o=0, dist_o=0.
// - Reset also clears seg_cnt, cls_cnt, acc, best_dist and best_cls.
// - A beat is accepted when in_valid_i && in_ready_o.
// - Beat order is class-major, segment-minor: class 0 seg 0..NSEG-1, then class 1, and so on.
// - Beats are counted internally; there is no last flag.
// - State ACCUM: in_ready_o=1, out_valid_o=0.
//   - Accepted beat, seg_cnt<NSEG-1: acc<=acc+pc_i; seg_cnt++.
//   - Accepted beat, seg_cnt==NSEG-1: sum=acc+pc_i; acc<=0; seg_cnt<=0.
//     - cls_cnt==0: load best<=(sum,0).
//     - cls_cnt>0: load best<=(sum,cls_cnt) only if sum<best_dist. Strict compare; ties keep the lower index.
//     - cls_cnt==NC-1: register the final best into class_o/dist_o; cls_cnt<=0; go to RESULT.
//     - otherwise: cls_cnt++.
// - State RESULT: in_ready_o=0, out_valid_o=1.
//   - class_o and dist_o are held stable until out_ready_i.
//   - On handshake: out_valid_o<=0, go to ACCUM. in_ready_o=1 on the next cycle.
// - Latency: out_valid_o rises on the cycle after the final beat is accepted.
// - Throughput: 1 beat/cycle in ACCUM. Minimum 1 bubble per query (the RESULT cycle).
// - Idle cycles (in_valid_i=0) between beats are allowed; no state changes on them.
// - Width: all sums zero-extended to DISTW.
//   - Max distance NSEG*2^(PCW-1) fits DISTW. No saturation needed; overflow is impossible.
// - rst_i has priority over every event; a partial query is discarded.
// - pc_i and in_valid_i are ignored while in_ready_o=0.
// TESTING (tests 2-6 use NSEG=2, NC=3, PCW=6)
// 1. Reset: assert rst_i 2 cycles -> in_ready_o=1, out_valid_o=0, class_o=0, dist_o=0.
// 2. Basic: pcs {5,7},{3,4},{10,0}.
//    -> class_o=1, dist_o=7; out_valid_o high the cycle after beat 6.
// 3. Tie: {4,4},{2,6},{8,0} (all 8) -> class_o=0, dist_o=8.
//    Then {9,0},{4,1},{1,4} -> class_o=1, dist_o=5.
// 4. Backpressure: test 2 with out_ready_i=0 for 5 cycles.
//    -> class_o=1 and dist_o=7 stable; in_ready_o=0; beats offered meanwhile are not consumed.
//    Then handshake -> in_ready_o=1 next cycle.
// 5. Gaps: test 2 with random 0-3 idle cycles between beats -> class_o=1, dist_o=7.
// 6. Reset mid-query: 3 beats of {9,9},{9,...; rst_i 1 cycle; then test 2 stimulus -> class_o=1, dist_o=7.
// 7. Full range, defaults (NSEG=32, NC=10):
//    - All pc_i=32 except class 9 all 0 -> class_o=9, dist_o=0.
//    - All pc_i=32 -> class_o=0, dist_o=1024.
// 8. Back-to-back queries with out_ready_i tied high.
//    -> one result per NC*NSEG+1 cycles, each matching a reference model.

Source files
------------

// File: rtl/hamming_argmin_if.sv
// Beat/result handshake bundle for the Hamming argmin stage.
// The slave modport is the stage itself; the master modport is the upstream/downstream side.
interface hamming_argmin_if #(
    parameter int PCW  = 6,
    parameter int NSEG = 32,
    parameter int NC   = 10
) ();
    localparam int DISTW = PCW + $clog2(NSEG);
    localparam int CIW   = $clog2(NC);

    logic             in_valid_i;
    logic             in_ready_o;
    logic [PCW-1:0]   pc_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [CIW-1:0]   class_o;
    logic [DISTW-1:0] dist_o;

    modport slave (
        input  in_valid_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, class_o, dist_o
    );

    modport master (
        output in_valid_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, class_o, dist_o
    );
endinterface

// File: rtl/hamming_argmin.sv
// Streaming Hamming-distance accumulator and nearest-class search.
// Beats arrive class-major/segment-minor; one (class, distance) result per query.
module hamming_argmin #(
    parameter int PCW  = 6,
    parameter int NSEG = 32,
    parameter int NC   = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hamming_argmin_if.slave   bus
);
    localparam int DISTW = PCW + $clog2(NSEG);
    localparam int CIW   = $clog2(NC);
    localparam int SEGW  = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic {ACCUM, RESULT} state_t;

    state_t           state, state_n;
    logic [SEGW-1:0]  seg_cnt;
    logic [CIW-1:0]   cls_cnt;
    logic [DISTW-1:0] acc;
    logic [DISTW-1:0] best_dist;
    logic [CIW-1:0]   best_cls;
    logic [CIW-1:0]   cls_q;
    logic [DISTW-1:0] dist_q;

    logic             accept, last_seg, last_cls, take;
    logic [DISTW-1:0] sum, nb_dist;
    logic [CIW-1:0]   nb_cls;

    always_comb begin
        state_n         = state;
        bus.in_ready_o  = (state == ACCUM);
        bus.out_valid_o = (state == RESULT);
        accept   = bus.in_valid_i && bus.in_ready_o;
        last_seg = (seg_cnt == SEGW'(NSEG - 1));
        last_cls = (cls_cnt == CIW'(NC - 1));
        sum      = acc + DISTW'(bus.pc_i);
        // Strict less-than: on a tie the earlier (lower-index) class is kept.
        take     = (cls_cnt == '0) || (sum < best_dist);
        nb_dist  = take ? sum : best_dist;
        nb_cls   = take ? cls_cnt : best_cls;
        case (state)
            ACCUM:  if (accept && last_seg && last_cls) state_n = RESULT;
            RESULT: if (bus.out_ready_i)                state_n = ACCUM;
            default:                                    state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ACCUM;
            seg_cnt   <= '0;
            cls_cnt   <= '0;
            acc       <= '0;
            best_dist <= '0;
            best_cls  <= '0;
            cls_q     <= '0;
            dist_q    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                if (!last_seg) begin
                    acc     <= sum;
                    seg_cnt <= seg_cnt + SEGW'(1);
                end else begin
                    acc       <= '0;
                    seg_cnt   <= '0;
                    best_dist <= nb_dist;
                    best_cls  <= nb_cls;
                    if (last_cls) begin
                        cls_q   <= nb_cls;
                        dist_q  <= nb_dist;
                        cls_cnt <= '0;
                    end else begin
                        cls_cnt <= cls_cnt + CIW'(1);
                    end
                end
            end
        end
    end

    assign bus.class_o = cls_q;
    assign bus.dist_o  = dist_q;
endmodule

// File: tb/tb_hamming_argmin.sv
// Directed bench: a small instance (NSEG=2, NC=3) for protocol cases and a
// default-sized instance for full-range distances.
module tb_hamming_argmin;
    localparam int SNSEG = 2;
    localparam int SNC   = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hamming_argmin_if #(.PCW(6), .NSEG(SNSEG), .NC(SNC)) s ();
    hamming_argmin_if #(.PCW(6), .NSEG(32),    .NC(10))  d ();

    hamming_argmin #(.PCW(6), .NSEG(SNSEG), .NC(SNC)) u_small (.clk_i(clk), .rst_i(rst), .bus(s));
    hamming_argmin #(.PCW(6), .NSEG(32),    .NC(10))  u_full  (.clk_i(clk), .rst_i(rst), .bus(d));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one beat after 'gap' idle cycles; returns at the negedge after acceptance.
    task automatic s_beat(input int pc, input int gap);
        for (int g = 0; g < gap; g++) @(negedge clk);
        s.pc_i       = 6'(pc);
        s.in_valid_i = 1'b1;
        for (int n = 0; n < 20 && !s.in_ready_o; n++) @(negedge clk);
        if (!s.in_ready_o) chk("beat_stall", int'(s.in_ready_o), 1);
        @(negedge clk);
        s.in_valid_i = 1'b0;
    endtask

    task automatic s_query(input int p[SNSEG*SNC], input int maxgap,
                           input int ec, input int ed, input string tag);
        for (int i = 0; i < SNSEG*SNC; i++) begin
            s_beat(p[i], $urandom_range(maxgap, 0));
            if (i == SNSEG*SNC-2) chk({tag, "_vld_early"}, int'(s.out_valid_o), 0);
        end
        chk({tag, "_vld"},  int'(s.out_valid_o), 1);
        chk({tag, "_cls"},  int'(s.class_o), ec);
        chk({tag, "_dist"}, int'(s.dist_o), ed);
    endtask

    task automatic s_ack(input string tag);
        s.out_ready_i = 1'b1;
        @(negedge clk);
        s.out_ready_i = 1'b0;
        chk({tag, "_rdy_after"}, int'(s.in_ready_o), 1);
        chk({tag, "_vld_after"}, int'(s.out_valid_o), 0);
    endtask

    task automatic d_query(input int zc, input int ec, input int ed, input string tag);
        chk({tag, "_rdy"}, int'(d.in_ready_o), 1);
        for (int c = 0; c < 10; c++)
            for (int g = 0; g < 32; g++) begin
                d.pc_i       = (c == zc) ? 6'd0 : 6'd32;
                d.in_valid_i = 1'b1;
                @(negedge clk);
            end
        d.in_valid_i = 1'b0;
        chk({tag, "_vld"},  int'(d.out_valid_o), 1);
        chk({tag, "_cls"},  int'(d.class_o), ec);
        chk({tag, "_dist"}, int'(d.dist_o), ed);
        d.out_ready_i = 1'b1;
        @(negedge clk);
        d.out_ready_i = 1'b0;
        chk({tag, "_rdy_after"}, int'(d.in_ready_o), 1);
    endtask

    int t2[SNSEG*SNC] = '{5, 7, 3, 4, 10, 0};
    int t3a[SNSEG*SNC] = '{4, 4, 2, 6, 8, 0};
    int t3b[SNSEG*SNC] = '{9, 0, 4, 1, 1, 4};

    initial begin
        int rp[SNSEG*SNC];
        int ec, ed, sum, last_cyc;
        rst = 1'b1;
        s.in_valid_i = 1'b0; s.pc_i = '0; s.out_ready_i = 1'b0;
        d.in_valid_i = 1'b0; d.pc_i = '0; d.out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_rdy",   int'(s.in_ready_o), 1);
        chk("rst_vld",   int'(s.out_valid_o), 0);
        chk("rst_cls",   int'(s.class_o), 0);
        chk("rst_dist",  int'(s.dist_o), 0);
        chk("rst_frdy",  int'(d.in_ready_o), 1);
        chk("rst_fdist", int'(d.dist_o), 0);

        s_query(t2, 0, 1, 7, "basic");   s_ack("basic");
        s_query(t3a, 0, 0, 8, "tie");    s_ack("tie");
        s_query(t3b, 0, 1, 5, "tie2");   s_ack("tie2");

        // Results must hold and offered beats must be refused while stalled.
        s_query(t2, 0, 1, 7, "bp");
        for (int k = 0; k < 5; k++) begin
            s.in_valid_i = 1'b1;
            s.pc_i       = 6'd31;
            @(negedge clk);
            chk("bp_cls",  int'(s.class_o), 1);
            chk("bp_dist", int'(s.dist_o), 7);
            chk("bp_rdy",  int'(s.in_ready_o), 0);
            chk("bp_vld",  int'(s.out_valid_o), 1);
        end
        s_ack("bp");
        s.in_valid_i = 1'b0;

        s_query(t2, 3, 1, 7, "gaps");    s_ack("gaps");

        for (int k = 0; k < 3; k++) s_beat(9, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rdy", int'(s.in_ready_o), 1);
        chk("midrst_vld", int'(s.out_valid_o), 0);
        s_query(t2, 0, 1, 7, "midrst");  s_ack("midrst");

        d_query(9, 9, 0, "full_zero9");
        d_query(-1, 0, 1024, "full_max");

        // Back-to-back queries with out_ready tied high, checked against a model.
        s.out_ready_i = 1'b1;
        last_cyc = 0;
        for (int q = 0; q < 4; q++) begin
            ec = 0; ed = 0;
            for (int c = 0; c < SNC; c++) begin
                sum = 0;
                for (int g = 0; g < SNSEG; g++) begin
                    rp[c*SNSEG+g] = $urandom_range(32, 0);
                    sum += rp[c*SNSEG+g];
                end
                if (c == 0 || sum < ed) begin ec = c; ed = sum; end
            end
            for (int i = 0; i < SNSEG*SNC; i++) s_beat(rp[i], 0);
            chk("b2b_vld",  int'(s.out_valid_o), 1);
            chk("b2b_cls",  int'(s.class_o), ec);
            chk("b2b_dist", int'(s.dist_o), ed);
            if (q > 0) chk("b2b_period", cyc - last_cyc, SNSEG*SNC + 1);
            last_cyc = cyc;
        end
        @(negedge clk);
        s.out_ready_i = 1'b0;
        chk("b2b_end_rdy", int'(s.in_ready_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
